// File: rtl/count_clusters_pipe.sv
// Pipelined cluster counter: 6-bit group popcounts feed a registered pairwise adder tree.
// Optional peak/overflow-event statistics are enabled with COUNT_CLUSTERS_PIPE_STATS_EN.
module count_clusters_pipe #(
  parameter int NUM_VPFS   = 1536,
  parameter int OVF_THRESH = 8,
  parameter int CNT_W      = 11
) (
  input  logic                clock4x,
  input  logic                reset,
  input  logic [NUM_VPFS-1:0] vpfs_i,
  input  logic                valid_i,
  input  logic                clear_i,
  output logic [CNT_W-1:0]    cnt_o,
  output logic                valid_o,
  output logic                overflow_o,
  output logic [CNT_W-1:0]    peak_o,
  output logic [15:0]         ovf_evt_o
);

  localparam int G     = (NUM_VPFS + 5) / 6;
  localparam int S     = $clog2(G);
  localparam int SUM_W = 3 + S;

  function automatic int nodes_at(input int lvl);
    return (G + (1 << lvl) - 1) >> lvl;
  endfunction

  function automatic logic [2:0] pop6(input logic [5:0] b);
    logic [2:0] acc;
    acc = '0;
    for (int i = 0; i < 6; i++) acc = acc + {2'b00, b[i]};
    return acc;
  endfunction

  if (CNT_W != $clog2(NUM_VPFS + 1)) begin : g_cnt_w_chk
    $error("CNT_W must equal clog2(NUM_VPFS+1)");
  end
  if (NUM_VPFS < 6 || NUM_VPFS > 3072) begin : g_range_chk
    $error("NUM_VPFS out of range 6..3072");
  end

  // Stage 0: input capture; vld_q[k] marks stage k holding a real sample.
  logic [NUM_VPFS-1:0] vpfs_q;
  logic [S+1:0]        vld_q;

  always_ff @(posedge clock4x) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset) begin
      vpfs_q <= '0;
      vld_q  <= '0;
    end else begin
      vpfs_q <= vpfs_i;
      vld_q  <= {vld_q[S:0], valid_i};
    end
  end

  logic [6*G-1:0] pad_w;
  always_comb begin
    // NOTE: defaulting the whole vector first keeps this block free of inferred latches.
    pad_w                 = '0;
    pad_w[NUM_VPFS-1:0]   = vpfs_q;
  end

  // Level 0 is the group popcount stage; level l has ceil(G/2^l) nodes of width 3+l.
  for (genvar l = 0; l <= S; l++) begin : g_lvl
    localparam int N  = nodes_at(l);
    localparam int W  = 3 + l;
    localparam int NP = nodes_at((l == 0) ? 0 : l - 1);
    for (genvar n = 0; n < N; n++) begin : g_node
      logic [W-1:0] sum_q;
      if (l == 0) begin : g_leaf
        always_ff @(posedge clock4x) begin
          // NOTE: every pipeline register is reset so a mid-stream reset leaves no stale partial sums.
          if (reset) sum_q <= '0;
          else       sum_q <= pop6(pad_w[6*n +: 6]);
        end
      end else if (2*n + 1 < NP) begin : g_pair
        always_ff @(posedge clock4x) begin
          if (reset) sum_q <= '0;
          else       sum_q <= {1'b0, g_lvl[l-1].g_node[2*n].sum_q}
                            + {1'b0, g_lvl[l-1].g_node[2*n+1].sum_q};
        end
      end else begin : g_pass
        always_ff @(posedge clock4x) begin
          if (reset) sum_q <= '0;
          else       sum_q <= {1'b0, g_lvl[l-1].g_node[2*n].sum_q};
        end
      end
    end
  end

  // Overflow is judged on the full tree width, before any truncation to CNT_W.
  logic [SUM_W-1:0] sum_full;
  logic             ovf_full;
  assign sum_full = g_lvl[S].g_node[0].sum_q;
  assign ovf_full = int'({{(32-SUM_W){1'b0}}, sum_full}) > OVF_THRESH;

  logic [CNT_W-1:0] cnt_q;
  logic             ovf_q;
  logic             vout_q;

  always_ff @(posedge clock4x) begin
    if (reset) begin
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      vout_q <= 1'b0;
    end else begin
      vout_q <= vld_q[S+1];
      cnt_q  <= vld_q[S+1] ? sum_full[CNT_W-1:0] : '0;
      ovf_q  <= vld_q[S+1] & ovf_full;
    end
  end

  assign cnt_o      = cnt_q;
  assign overflow_o = ovf_q;
  assign valid_o    = vout_q;

`ifdef COUNT_CLUSTERS_PIPE_STATS_EN
  logic [CNT_W-1:0] peak_q, peak_d;
  logic [15:0]      evt_q, evt_d;

  // A result presented in the same cycle as clear_i is dropped from the statistics.
  always_comb begin
    peak_d = peak_q;
    evt_d  = evt_q;
    if (clear_i) begin
      peak_d = '0;
      evt_d  = '0;
    end else if (vout_q) begin
      if (cnt_q > peak_q) peak_d = cnt_q;
      if (ovf_q && (evt_q != 16'hFFFF)) evt_d = evt_q + 16'd1;
    end
  end

  always_ff @(posedge clock4x) begin
    if (reset) begin
      peak_q <= '0;
      evt_q  <= '0;
    end else begin
      peak_q <= peak_d;
      evt_q  <= evt_d;
    end
  end

  assign peak_o    = peak_q;
  assign ovf_evt_o = evt_q;
`else
  logic unused_clear;
  assign unused_clear = clear_i;
  assign peak_o       = '0;
  assign ovf_evt_o    = '0;
`endif

endmodule

// File: tb/tb_count_clusters_pipe.sv
// Self-checking bench for count_clusters_pipe: directed table, reset/stats sequences,
// random stream against a popcount model, and an exhaustive NUM_VPFS=13 instance.
module tb_count_clusters_pipe;

  localparam int NV    = 1536;
  localparam int CW    = 11;
  localparam int LAT   = 11;
  localparam int NV13  = 13;
  localparam int CW13  = 4;
  localparam int LAT13 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, valid, clear;
  logic [NV-1:0] vpfs;
  logic [CW-1:0] cnt, peak;
  logic          vout, ovf;
  logic [15:0]   evt;

  logic [NV13-1:0] vpfs13;
  logic            valid13;
  logic [CW13-1:0] cnt13, peak13;
  logic            vout13, ovf13;
  logic [15:0]     evt13;

  count_clusters_pipe #(.NUM_VPFS(NV), .OVF_THRESH(8), .CNT_W(CW)) dut (
    .clock4x(clk), .reset(reset), .vpfs_i(vpfs), .valid_i(valid), .clear_i(clear),
    .cnt_o(cnt), .valid_o(vout), .overflow_o(ovf), .peak_o(peak), .ovf_evt_o(evt));

  count_clusters_pipe #(.NUM_VPFS(NV13), .OVF_THRESH(8), .CNT_W(CW13)) dut13 (
    .clock4x(clk), .reset(reset), .vpfs_i(vpfs13), .valid_i(valid13), .clear_i(clear),
    .cnt_o(cnt13), .valid_o(vout13), .overflow_o(ovf13), .peak_o(peak13), .ovf_evt_o(evt13));

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    logic [NV-1:0] vec;
    int            exp_cnt;
    logic          exp_ovf;
    string         name;
  } vec_t;

  typedef struct {
    logic v;
    int   c;
  } exp_t;

  vec_t tbl[6];
  exp_t q[$];
  exp_t q13[$];

  function automatic logic [NV-1:0] rand_vec(input int mode);
    logic [NV-1:0] v;
    v = '0;
    case (mode)
      0: for (int w = 0; w < NV/32; w++) v[w*32 +: 32] = $urandom;
      1: for (int k = 0; k < int'($urandom_range(0, 12)); k++) v[$urandom_range(0, NV-1)] = 1'b1;
      2: v = '0;
      default: v = '1;
    endcase
    return v;
  endfunction

  function automatic logic [NV-1:0] low_ones(input int n);
    logic [NV-1:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  // One sample in, idle otherwise; result must appear exactly LAT cycles later for one cycle.
  task automatic single_sample(input logic [NV-1:0] vec, input int exp_c, input logic exp_o,
                               input string name);
    @(negedge clk);
    vpfs  = vec;
    valid = 1'b1;
    for (int k = 1; k <= LAT + 1; k++) begin
      @(negedge clk);
      if (k == LAT - 1) check({name, " early valid"}, 32'(vout), 32'd0);
      if (k == LAT) begin
        check({name, " valid"}, 32'(vout), 32'd1);
        check({name, " cnt"},   32'(cnt),  32'(exp_c));
        check({name, " ovf"},   32'(ovf),  32'(exp_o));
      end
      if (k == LAT + 1) begin
        check({name, " valid drop"}, 32'(vout), 32'd0);
        check({name, " cnt hold0"},  32'(cnt),  32'd0);
      end
      if (k == 1) begin
        valid = 1'b0;
        vpfs  = rand_vec(0);
      end
    end
  endtask

  int cs[5] = '{3, 12, 7, 20, 30};
  int pk[4] = '{3, 12, 12, 20};
  int ev[4] = '{0, 1, 1, 2};

  initial begin
    logic [NV-1:0] v;
    exp_t e;

    reset = 1'b1; valid = 1'b0; clear = 1'b0; vpfs = '0;
    vpfs13 = '0; valid13 = 1'b0;
    repeat (3) @(negedge clk);
    check("reset cnt",   32'(cnt),   32'd0);
    check("reset valid", 32'(vout),  32'd0);
    check("reset ovf",   32'(ovf),   32'd0);
    check("reset peak",  32'(peak),  32'd0);
    check("reset evt",   32'(evt),   32'd0);
    check("reset valid13", 32'(vout13), 32'd0);
    reset = 1'b0;

    v = '1;
    tbl[0] = '{v, 1536, 1'b1, "all ones"};
    v = '0; v[0] = 1; v[5] = 1; v[6] = 1; v[767] = 1; v[1535] = 1;
    tbl[1] = '{v, 5, 1'b0, "five bits"};
    v[100] = 1; v[200] = 1; v[300] = 1; v[1000] = 1;
    tbl[2] = '{v, 9, 1'b1, "nine bits"};
    v[1000] = 0;
    tbl[3] = '{v, 8, 1'b0, "eight bits"};
    v = '0;
    tbl[4] = '{v, 0, 1'b0, "zero"};
    v[1535:1530] = '1; v[2:0] = '1;
    tbl[5] = '{v, 9, 1'b1, "edge groups"};

    for (int i = 0; i < 6; i++) single_sample(tbl[i].vec, tbl[i].exp_cnt, tbl[i].exp_ovf, tbl[i].name);

    // Random stream with clear_i toggling, which must not disturb the count path.
    for (int i = 0; i < LAT; i++) q.push_back('{1'b0, 0});
    for (int t = 0; t < 1000 + LAT; t++) begin
      @(negedge clk);
      e = q.pop_front();
      check("rand valid", 32'(vout), 32'(e.v));
      check("rand cnt",   32'(cnt),  32'(e.c));
      check("rand ovf",   32'(ovf),  32'(e.v && e.c > 8));
`ifndef COUNT_CLUSTERS_PIPE_STATS_EN
      check("rand peak tied", 32'(peak), 32'd0);
      check("rand evt tied",  32'(evt),  32'd0);
`endif
      if (t < 1000) begin
        valid = 1'($urandom_range(0, 1));
        vpfs  = rand_vec(int'($urandom_range(0, 3)));
        clear = 1'($urandom_range(0, 1));
      end else begin
        valid = 1'b0;
        clear = 1'b0;
      end
      q.push_back('{valid, valid ? $countones(vpfs) : 0});
    end

    // Reset four cycles after a valid sample: that sample must never emerge.
    @(negedge clk);
    vpfs = '1; valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(negedge clk);
      if (k == 1) valid = 1'b0;
      if (k == 4) reset = 1'b1;
    end
    @(negedge clk);
    check("midrst cnt",   32'(cnt),  32'd0);
    check("midrst valid", 32'(vout), 32'd0);
    check("midrst ovf",   32'(ovf),  32'd0);
    check("midrst peak",  32'(peak), 32'd0);
    check("midrst evt",   32'(evt),  32'd0);
    reset = 1'b0;
    for (int k = 0; k < LAT + 2; k++) begin
      @(negedge clk);
      check("midrst discard", 32'(vout), 32'd0);
    end
    single_sample(low_ones(13), 13, 1'b1, "post reset");

    // Exhaustive 13-bit instance: padding plus an odd group count.
    for (int i = 0; i < LAT13; i++) q13.push_back('{1'b0, 0});
    for (int t = 0; t < 8192 + LAT13; t++) begin
      @(negedge clk);
      e = q13.pop_front();
      if (e.v || t < 4) begin
        check("x13 valid", 32'(vout13), 32'(e.v));
        check("x13 cnt",   32'(cnt13),  32'(e.c));
        check("x13 ovf",   32'(ovf13),  32'(e.v && e.c > 8));
      end
      valid13 = (t < 8192);
      vpfs13  = 13'(t);
      q13.push_back('{valid13, valid13 ? $countones(vpfs13) : 0});
    end
    @(negedge clk);
    check("x13 drained", 32'(vout13), 32'd0);

`ifdef COUNT_CLUSTERS_PIPE_STATS_EN
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("stats cleared peak", 32'(peak), 32'd0);
    check("stats cleared evt",  32'(evt),  32'd0);
    for (int k = 0; k <= LAT + 5; k++) begin
      @(negedge clk);
      if (k >= LAT && k < LAT + 5) check("stats cnt", 32'(cnt), 32'(cs[k-LAT]));
      if (k >= LAT + 1 && k < LAT + 5) begin
        check("stats peak", 32'(peak), 32'(pk[k-LAT-1]));
        check("stats evt",  32'(evt),  32'(ev[k-LAT-1]));
      end
      if (k == LAT + 5) begin
        check("clear peak", 32'(peak), 32'd0);
        check("clear evt",  32'(evt),  32'd0);
      end
      valid = (k < 5);
      vpfs  = (k < 5) ? low_ones(cs[k]) : '0;
      clear = (k == LAT + 4);
    end
    clear = 1'b0;
    vpfs = '1; valid = 1'b1;
    repeat (70000) @(negedge clk);
    valid = 1'b0;
    repeat (LAT + 2) @(negedge clk);
    check("evt saturate", 32'(evt),  32'hFFFF);
    check("peak full",    32'(peak), 32'd1536);
`else
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    check("peak tied", 32'(peak), 32'd0);
    check("evt tied",  32'(evt),  32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/count_clusters_pipe.md
COUNT_CLUSTERS_PIPE -- requirements
Module: count_clusters_pipe

Interface
REQ-001 Parameter NUM_VPFS, default 1536: width of the valid-pattern-flag vector; legal range 6..3072.
REQ-002 Parameter OVF_THRESH, default 8: overflow asserts when count strictly exceeds this value.
REQ-003 Parameter CNT_W, default 11: count width; SHALL equal clog2(NUM_VPFS+1), checked at elaboration (error on mismatch).
REQ-004 clock4x  input  1  sole clock; all state updates on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 vpfs_i  input  NUM_VPFS  cluster valid flags, one bit per candidate cluster.
REQ-007 valid_i  input  1  qualifies vpfs_i for the current cycle.
REQ-008 clear_i  input  1  synchronous clear of peak/overflow statistics.
REQ-009 cnt_o  output  CNT_W  number of set bits in the sampled vpfs_i.
REQ-010 valid_o  output  1  qualifies cnt_o and overflow_o.
REQ-011 overflow_o  output  1  cnt_o > OVF_THRESH, same cycle as cnt_o.
REQ-012 peak_o  output  CNT_W  largest cnt_o seen since reset/clear.
REQ-013 ovf_evt_o  output  16  saturating count of valid overflow results since reset/clear.

Function
REQ-014 vpfs_i and valid_i SHALL be registered on entry (stage 0).
REQ-015 Stage 1 SHALL count each 6-bit group with a single-level 3-bit popcount; vector zero-padded to G = ceil(NUM_VPFS/6) groups.
REQ-016 Stages 2..S+1 SHALL form a pairwise registered adder tree, S = ceil(log2(G)); odd leftover entry passes through registered, added to zero.
REQ-017 Each tree stage SHALL widen by one bit, final sum truncation only to CNT_W (never overflows by construction).
REQ-018 Output stage SHALL register cnt_o, overflow_o and valid_o together; total latency L = S+3 cycles (L=11 for NUM_VPFS=1536, L=10 for 768).
REQ-019 valid SHALL travel a shift register in parallel with the tree; one result per input cycle, no back-pressure, full throughput.
REQ-020 When valid_o is 0, cnt_o and overflow_o SHALL hold 0.
REQ-021 overflow_o SHALL compare the full-width sum, never a truncated value.
REQ-022 peak_o SHALL update to cnt_o when valid_o=1 and cnt_o > peak_o; equal values leave it unchanged.
REQ-023 ovf_evt_o SHALL increment when valid_o=1 and overflow_o=1; holds at 16'hFFFF once reached.
REQ-024 clear_i SHALL zero peak_o and ovf_evt_o next cycle; a result arriving the same cycle as clear_i is discarded from the statistics.
REQ-025 clear_i SHALL NOT affect the count pipeline or valid_o.

Reset
REQ-026 reset SHALL zero every pipeline register, valid stage, cnt_o, overflow_o, valid_o, peak_o and ovf_evt_o on the next edge.
REQ-027 Reset mid-stream SHALL discard all in-flight samples; first valid_o after deassertion corresponds to a sample taken at or after deassertion, L cycles later.
REQ-028 reset SHALL take priority over clear_i and valid_i.

Configuration
REQ-029 Macro COUNT_CLUSTERS_PIPE_STATS_EN defined: peak_o and ovf_evt_o logic per REQ-022..024 compiled in.
REQ-030 Macro undefined: ports peak_o and ovf_evt_o remain, tied to 0; clear_i ignored; counting path unchanged.

Verification
REQ-031 NUM_VPFS=1536, vpfs_i all ones, valid_i=1 one cycle -> 11 cycles later cnt_o=1536, overflow_o=1, valid_o=1 for one cycle.
REQ-032 vpfs_i bits 0,5,6,767,1535 set -> cnt_o=5, overflow_o=0; repeat with 9 bits set -> cnt_o=9, overflow_o=1; exactly 8 set -> overflow_o=0.
REQ-033 Back-to-back random vectors for 1000 cycles with valid_i toggling -> every cnt_o matches reference popcount L cycles later; valid_o mirrors valid_i delayed by L.
REQ-034 reset asserted 4 cycles after a valid sample -> no valid_o for that sample; all outputs 0 one cycle after reset edge.
REQ-035 STATS_EN: counts 3,12,7,20 -> peak_o 3,12,12,20, ovf_evt_o 0,1,1,2; clear_i coincident with count 30 -> peak_o=0, ovf_evt_o=0; 70000 overflow results -> ovf_evt_o=16'hFFFF.
REQ-036 NUM_VPFS=13 (padding, odd groups) exhaustive 8192 vectors -> cnt_o equals popcount; L = ceil(log2(3))+3 = 5.
